// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full adder/subtractor cell and one carry/borrow
// flop process the operands LSB first, one bit per clock, under an IDLE/RUN/DONE FSM.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_q, op_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               ai_s, bi_s, bit_s, c_next_s;

  // Serial cell plus next-state logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    ai_s  = a_q[0];
    bi_s  = b_q[0];
    bit_s = ai_s ^ bi_s ^ c_q;
    if (op_q) begin
      c_next_s = (~ai_s & bi_s) | (~(ai_s ^ bi_s) & c_q);
    end else begin
      c_next_s = (ai_s & bi_s) | (ai_s & c_q) | (bi_s & c_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          a_d      = a;
          b_d      = b;
          op_d     = op;
          c_d      = 1'b0;
          cnt_d    = {CNT_W{1'b0}};
          result_d = {WIDTH{1'b0}};
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d = {bit_s, result_q[WIDTH-1:1]};
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        c_d      = c_next_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Overflow: carry/borrow into the MSB differs from the one out of it
          state_d = S_DONE;
          cout_d  = c_next_s;
          ovf_d   = c_q ^ c_next_s;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      result_q <= {WIDTH{1'b0}};
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
